// File: rtl/serial_adder_if.sv
// Start/operand/result bundle for serial_adder. The requester drives the
// master side and the adder implements the slave side.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_overflow;

    modport master (
        output i_start, i_sub, i_a, i_b, i_cin,
        input  o_busy, o_done, o_result, o_cout, o_overflow
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b, i_cin,
        output o_busy, o_done, o_result, o_cout, o_overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice is reused over
// WIDTH/DIGIT cycles, least-significant digit first, with a registered carry.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    serial_adder_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ov_q, ov_d;

    logic [DIGIT:0]       digit_sum;
    logic                 c_msb;
    logic [WIDTH+DIGIT-1:0] sum_shifted;
    logic                 last_digit;

    // One digit slice: the carry into the slice MSB is recovered from s ^ a ^ b.
    assign digit_sum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};
    assign c_msb       = digit_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    assign sum_shifted = {digit_sum[DIGIT-1:0], sum_q} >> DIGIT;
    assign last_digit  = (cnt_q == CNT_W'(N - 1));

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the case leaves it unassigned (no latch).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ov_d     = ov_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_sub ? ~bus.i_b : bus.i_b;
                    carry_d = bus.i_sub ^ bus.i_cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_shifted[WIDTH-1:0];
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    result_d = sum_shifted[WIDTH-1:0];
                    cout_d   = digit_sum[DIGIT];
                    ov_d     = c_msb ^ digit_sum[DIGIT];
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ov_q     <= ov_d;
        end
    end

    assign bus.o_busy     = (state_q == RUN);
    assign bus.o_done     = (state_q == DONE);
    assign bus.o_result   = result_q;
    assign bus.o_cout     = cout_q;
    assign bus.o_overflow = ov_q;
endmodule
